uart_rx_os: RTL and testbench

//  Oversampling UART receiver for the serial link: recovers 8N1 frames from the asynchronous
//  rxd line and delivers bytes to system A over a valid/ready handshake.

---
 rtl/uart_rx_os.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with valid/ready byte output and error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_os #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       par_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          rxd_meta, rxd_s, rxd_s_d;
    logic          good_byte, stop_bad, par_bad;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_s_d  <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_s_d  <= rxd_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_reg, par_bit_next;
    logic par_mismatch;
    assign par_mismatch = ^{shift_reg, par_bit_reg};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            shift_reg   <= shift_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= par_bit_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        idx_next     = idx_reg;
        shift_next   = shift_reg;
        good_byte    = 1'b0;
        stop_bad     = 1'b0;
        par_bad      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Only a true edge starts a frame; a line held low stays locked out.
                cnt_next = '0;
                if (rxd_s_d && !rxd_s)
                    state_next = START;
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next            = '0;
                    shift_next[idx_reg] = rxd_s;
                    idx_next            = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    par_bit_next = rxd_s;
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (!rxd_s)
                        stop_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (par_mismatch)
                        par_bad = 1'b1;
`endif
                    else
                        good_byte = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register: a delivery in the same cycle as a consume keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= good_byte && valid && !ready;
            if (good_byte && (!valid || ready)) begin
                data  <= shift_reg;
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_err <= 1'b0;
        else
            par_err <= par_bad;
    end
`else
    assign par_err = 1'b0;
    logic unused_par;
    assign unused_par = par_bad;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed table, hand-written corner sequences,
// and randomized frames scored against a frame-level outcome model.
module tb_uart_rx_os;
    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int LAT    = 155 + BIT;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int LAT    = 155;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, par_err, overrun;

    uart_rx_os #(.CLK_DIV(BIT)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
        .ready(ready), .frame_err(frame_err), .par_err(par_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record handshakes, valid timing and error pulse cycles.
    logic [7:0] got_q[$];
    int valid_hi_cnt = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
    int rise_cyc = 0, ovr_cyc = 0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) got_q.push_back(data);
            if (valid) valid_hi_cnt <= valid_hi_cnt + 1;
            if (valid && !valid_prev) rise_cyc <= cyc;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (par_err) perr_cnt <= perr_cnt + 1;
            if (overrun) begin
                ovr_cnt <= ovr_cnt + 1;
                ovr_cyc <= cyc;
            end
        end
        valid_prev <= valid;
    end

    int tests = 0, fails = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_level(input logic lvl, input int n);
        rxd = lvl;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        logic [7:0] bv;
        logic       pf;
        bv = b;
        pf = par_flip;
        start_cyc = cyc;
        drive_level(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_level(bv[i], BIT);
        if (PAR_EN) drive_level((^bv) ^ pf, BIT);
        drive_level(stop_bit, BIT);
    endtask

    // Frame-level reference: outcome depends only on stop level and parity agreement.
    function automatic logic [2:0] model(input logic stop_bit, input logic par_flip);
        logic fe, pe, dlv;
        fe  = !stop_bit;
        pe  = stop_bit && PAR_EN && par_flip;
        dlv = stop_bit && !pe;
        return {dlv, fe, pe};
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] b, input logic stop_bit,
                             input logic par_flip, input int gap,
                             input logic exp_dlv, input int exp_fe, input int exp_pe);
        int fe0, pe0, ov0;
        logic [7:0] got;
        fe0 = ferr_cnt;
        pe0 = perr_cnt;
        ov0 = ovr_cnt;
        got_q.delete();
        send_frame(b, stop_bit, par_flip);
        if (gap > 0) drive_level(1'b1, gap);
        rxd = 1'b1;
        check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_dlv));
        if (got_q.size() > 0 && exp_dlv) begin
            got = got_q.pop_front();
            check({tag, "_data"}, 32'(got), 32'(b));
        end
        check({tag, "_ferr"}, 32'(ferr_cnt - fe0), 32'(exp_fe));
        check({tag, "_perr"}, 32'(perr_cnt - pe0), 32'(exp_pe));
        check({tag, "_ovr"}, 32'(ovr_cnt - ov0), 32'd0);
        $display("[TB] %s byte=%02h stop=%0b flip=%0b gap=%0d exp_dlv=%0b", tag, b, stop_bit,
                 par_flip, gap, exp_dlv);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop_bit;
        logic       par_flip;
        int         gap;
        logic       exp_dlv;
        int         exp_fe;
        int         exp_pe;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int v0, fe0, ov0, p2;
        logic [7:0] rb;
        logic [7:0] pat;
        logic       rs, rf;
        int         rg;
        logic [2:0] m;

        tbl[0] = '{8'h00, 1'b1, 1'b0, 0, 1'b1, 0, 0};
        tbl[1] = '{8'hFF, 1'b1, 1'b0, 3, 1'b1, 0, 0};
        tbl[2] = '{8'h3C, 1'b1, 1'b0, 2, 1'b1, 0, 0};
        tbl[3] = '{8'hC3, 1'b0, 1'b0, 5, 1'b0, 1, 0};
`ifdef UART_RX_PARITY_EN
        tbl[4] = '{8'h07, 1'b1, 1'b1, 4, 1'b0, 0, 1};
`else
        tbl[4] = '{8'h07, 1'b1, 1'b1, 4, 1'b1, 0, 0};
`endif
        tbl[5] = '{8'h5B, 1'b1, 1'b0, 0, 1'b1, 0, 0};
        tbl[6] = '{8'h12, 1'b1, 1'b0, 3, 1'b1, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_perr", 32'(par_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        drive_level(1'b1, 10);

        // Frame 0xA5: latency and one-cycle valid
        v0 = valid_hi_cnt;
        run_frame("t1_a5", 8'hA5, 1'b1, 1'b0, 4, 1'b1, 0, 0);
        check("t1_valid_lat", 32'(rise_cyc - start_cyc), 32'(LAT));
        check("t1_valid_width", 32'(valid_hi_cnt - v0), 32'd1);

        for (int i = 0; i < 7; i++)
            run_frame("tbl", tbl[i].b, tbl[i].stop_bit, tbl[i].par_flip, tbl[i].gap,
                      tbl[i].exp_dlv, tbl[i].exp_fe, tbl[i].exp_pe);

        // Short low glitch in idle
        got_q.delete();
        fe0 = ferr_cnt;
        drive_level(1'b0, 5);
        drive_level(1'b1, 20);
        check("t3_glitch_nbytes", 32'(got_q.size()), 32'd0);
        check("t3_glitch_ferr", 32'(ferr_cnt - fe0), 32'd0);
        $display("[TB] glitch 5 clk low");
        run_frame("t3_3c", 8'h3C, 1'b1, 1'b0, 4, 1'b1, 0, 0);

        // Bad stop bit followed by a long low line
        got_q.delete();
        fe0 = ferr_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        drive_level(1'b0, 40);
        drive_level(1'b1, 4);
        check("t4_ferr", 32'(ferr_cnt - fe0), 32'd1);
        check("t4_nbytes", 32'(got_q.size()), 32'd0);
        check("t4_valid", 32'(valid), 32'd0);
        $display("[TB] byte=81 stop=0 then 40 clk low");
        run_frame("t4_7e", 8'h7E, 1'b1, 1'b0, 4, 1'b1, 0, 0);

        // Overrun with ready low
        ready = 1'b0;
        got_q.delete();
        ov0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        drive_level(1'b1, 4);
        send_frame(8'h22, 1'b1, 1'b0);
        p2 = start_cyc;
        drive_level(1'b1, 4);
        check("t5_ovr_cnt", 32'(ovr_cnt - ov0), 32'd1);
        check("t5_ovr_cyc", 32'(ovr_cyc - p2), 32'(LAT));
        check("t5_valid", 32'(valid), 32'd1);
        check("t5_data", 32'(data), 32'h11);
        $display("[TB] ready=0 bytes 11,22 overrun");
        ready = 1'b1;
        @(posedge clk);
        #2;
        check("t5_valid_drop", 32'(valid), 32'd0);
        check("t5_consumed_n", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("t5_consumed", 32'(got_q.pop_front()), 32'h11);
        $display("[TB] ready=1 consumed 11");

        // Asynchronous reset during DATA while a byte is pending
        ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        drive_level(1'b1, 4);
        check("t6_pending_valid", 32'(valid), 32'd1);
        pat = 8'h55;
        drive_level(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_level(pat[i], BIT);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(valid), 32'd0);
        check("t6_async_data", 32'(data), 32'd0);
        check("t6_async_errs", 32'({frame_err, par_err, overrun}), 32'd0);
        $display("[TB] rst during DATA of 55");
        @(posedge clk);
        #2;
        rxd = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        ready = 1'b1;
        drive_level(1'b1, 20);
        run_frame("t6_99", 8'h99, 1'b1, 1'b0, 4, 1'b1, 0, 0);

        // Randomized frames against the outcome model
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            rf = ($urandom_range(0, 4) == 0);
            rg = rs ? int'($urandom_range(0, 5)) : int'($urandom_range(2, 8));
            m  = model(rs, rf);
            run_frame("rand", rb, rs, rf, rg, m[2], int'(m[1]), int'(m[0]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
